fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the five-stage pipeline, sitting directly upstream of decode. It owns the fetch PC and a single-outstanding request/acknowledge interface to instruction memory. It buffers one instruction when decode stalls and handles branch/jump redirects from execute. Through the IF/ID register it drives `instrD`, `pcD`, `pcPlus4D` and `validD`, which the decode stage (including the immediate generator) consumes.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `stallD` input 1: hazard unit; hold the IF/ID register and stop handing over instructions.
- `flushD` input 1: hazard unit; load a bubble into IF/ID at the next edge.
- `pcSrcE` input 1: redirect request from execute (taken branch / jal / jalr).
- `pcTargetE` input 32: redirect target, valid when `pcSrcE`=1.
- `imemReq` output 1: fetch request; held until acknowledged.
- `imemAddr` output 32: fetch address; stable while `imemReq`=1 and not yet acked.
- `imemAck` input 1: memory has returned data this cycle; may be asserted in the same cycle as `imemReq` (zero-wait memory).
- `imemRdata` input 32: instruction word, valid with `imemAck`.
- `instrD` output 32: instruction to decode.
- `pcD` output 32: PC of `instrD`.
- `pcPlus4D` output 32: `pcD`+4.
- `validD` output 1: `instrD` is a real instruction; 0 means bubble.

## Operation
- Internal registers:
  - `pcF` (next address to fetch).
  - `redirTarget`.
  - One-entry skid buffer: instruction and PC.
  - State: IDLE, FETCH, BUFFERED, DROP.
- Bubble value: `instrD`=NOP 32'h0000_0013, `validD`=0; `pcD` and `pcPlus4D` are held.
- `imemReq`=1 in FETCH and DROP only. `imemAddr`=`pcF` in FETCH; in DROP it is the address still in flight, which is `pcF` unchanged.
- State transitions:
  - IDLE → FETCH unconditionally on the first edge after reset release.
  - FETCH, ack, no redirect, !stallD: deliver {`imemRdata`, `pcF`} to D; `pcF` += 4; stay in FETCH.
  - FETCH, ack, no redirect, stallD: write the skid buffer; `pcF` += 4; → BUFFERED.
  - FETCH, ack, `pcSrcE`: discard the data; `pcF` := `pcTargetE`; stay in FETCH.
  - FETCH, no ack, `pcSrcE`: `redirTarget` := `pcTargetE`; → DROP.
  - DROP, ack: discard the data; `pcF` := `redirTarget`; → FETCH.
  - DROP, `pcSrcE` again: overwrite `redirTarget`; a simultaneous ack uses the new target.
  - BUFFERED, `pcSrcE`: clear the buffer; `pcF` := `pcTargetE`; → FETCH.
  - BUFFERED, !stallD, no redirect: deliver the buffer to D; → FETCH.
- IF/ID update priority: `flushD` → bubble; else `stallD` → hold; else load the delivered instruction if any, otherwise a bubble.
- A redirect in the same cycle as a delivery means that instruction is not delivered.
- `flushD` alone never touches the skid buffer or `pcF`.
- PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 0; `pcPlus4D` wraps the same way.
- `pcTargetE` is used as given; alignment is execute's responsibility.

## Timing
- Reset values (all asserted asynchronously on `rst`, mid-operation included):
  - State IDLE, `imemReq`=0, `pcF`=`RESET_PC`, skid buffer empty.
  - `instrD`=NOP, `validD`=0, `pcD`=0, `pcPlus4D`=4.
- An in-flight request is abandoned by reset; its late ack is ignored because no request is pending.
- First `imemReq` goes out one cycle after `rst` deasserts.
- With zero-wait memory, an ack in cycle n puts the instruction in `instrD` after edge n+1. Throughput is one instruction per cycle.
- Redirect asserted in cycle n (FETCH or BUFFERED):
  - `imemAddr`=`pcTargetE` from cycle n+1.
  - With zero-wait memory, the target instruction appears in D after edge n+2.
- Memory is never issued a new address while a request is unacknowledged.

## Structure
- Shared package `pentarv_pkg`:
  - `NOP_INSTR` (32'h0000_0013).
  - Fetch state enum.
  - Default `RESET_PC`.
- Sub-module `if_id_reg`: the IF/ID register with flush/stall priority and bubble insertion, reused for the data path into decode.
- The FSM, `pcF`, `redirTarget` and the skid buffer live in `fetch_unit`.

## Test plan
- Reset with `RESET_PC`=32'h100 and zero-wait memory → `imemAddr` sequence 100, 104, 108; D shows each word one cycle after its ack; `validD`=1 from the third edge.
- `stallD` high for 3 cycles while an ack returns the word at 104 → `imemReq` drops after the ack, the buffer holds 104, D holds 100. On release, D=104 and the next request is 108.
- Memory acks after 3 cycles; `pcSrcE` with target 32'h200 in the first wait cycle → `imemAddr` stays 104 until the ack, that data is dropped, next address 200, `validD`=0 in between.
- `pcSrcE` coinciding with an ack → the acked word never reaches D; next `imemAddr` is the target.
- Fetch at 32'hFFFF_FFFC → `pcPlus4D`=0 and the next `imemAddr`=0.
- `rst` pulsed while waiting for an ack; the ack arrives during reset → all outputs take their reset values, and fetch restarts at `RESET_PC` one cycle after release.

Source files
------------

// File: rtl/pentarv_pkg.sv
// Shared definitions for the pentarv pipeline: fetch state encoding,
// the canonical bubble instruction and the default reset PC.
package pentarv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    BUFFERED,
    DROP
  } fetchStateT;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, and an empty slot loads a bubble.
// On a bubble the PC fields are held so decode still sees the last real PC.
module if_id_reg
  import pentarv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        inValid,
  input  logic [31:0] inInstr,
  input  logic [31:0] inPc,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcPlus4D,
  output logic        validD
);

  // Register update with flush > stall > load/bubble priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrD   <= NOP_INSTR;
      validD   <= 1'b0;
      pcD      <= '0;
      pcPlus4D <= 32'd4;
    end else if (flush) begin
      instrD <= NOP_INSTR;
      validD <= 1'b0;
    end else if (!stall) begin
      if (inValid) begin
        instrD   <= inInstr;
        validD   <= 1'b1;
        pcD      <= inPc;
        pcPlus4D <= pcPlus4(inPc);
      end else begin
        instrD <= NOP_INSTR;
        validD <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, a single-outstanding
// request/ack port to instruction memory, a one-entry skid buffer for
// decode stalls, and redirect handling from execute.
module fetch_unit
  import pentarv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcSrcE,
  input  logic [31:0] pcTargetE,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcPlus4D,
  output logic        validD
);

  fetchStateT  state;
  logic        reqQ;
  logic [31:0] pcF;
  logic [31:0] redirTarget;
  logic        bufValid;
  logic [31:0] bufInstr;
  logic [31:0] bufPc;

  logic        delivValid;
  logic [31:0] delivInstr;
  logic [31:0] delivPc;

  // In DROP the abandoned request is still in flight at pcF, so the
  // address is pcF in both requesting states.
  assign imemReq  = reqQ;
  assign imemAddr = pcF;

  // Select what, if anything, is handed to decode this cycle; a redirect
  // in the same cycle suppresses the hand-over.
  always_comb begin
    delivValid = 1'b0;
    delivInstr = NOP_INSTR;
    delivPc    = pcF;
    unique case (state)
      FETCH: begin
        if (imemAck && !pcSrcE && !stallD) begin
          delivValid = 1'b1;
          delivInstr = imemRdata;
          delivPc    = pcF;
        end
      end
      BUFFERED: begin
        if (bufValid && !pcSrcE && !stallD) begin
          delivValid = 1'b1;
          delivInstr = bufInstr;
          delivPc    = bufPc;
        end
      end
      default: ;
    endcase
  end

  // Fetch FSM with pcF, redirect target and skid buffer; imemReq is registered
  // alongside the state so it is high exactly in FETCH and DROP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      reqQ        <= 1'b0;
      pcF         <= RESET_PC;
      redirTarget <= '0;
      bufValid    <= 1'b0;
      bufInstr    <= NOP_INSTR;
      bufPc       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= FETCH;
          reqQ  <= 1'b1;
        end
        FETCH: begin
          if (imemAck) begin
            if (pcSrcE) begin
              pcF <= pcTargetE;
            end else begin
              pcF <= pcPlus4(pcF);
              if (stallD) begin
                bufValid <= 1'b1;
                bufInstr <= imemRdata;
                bufPc    <= pcF;
                state    <= BUFFERED;
                reqQ     <= 1'b0;
              end
            end
          end else if (pcSrcE) begin
            redirTarget <= pcTargetE;
            state       <= DROP;
          end
        end
        DROP: begin
          // A redirect arriving with the ack wins over the stored target.
          if (imemAck) begin
            pcF   <= pcSrcE ? pcTargetE : redirTarget;
            state <= FETCH;
          end else if (pcSrcE) begin
            redirTarget <= pcTargetE;
          end
        end
        BUFFERED: begin
          if (pcSrcE) begin
            bufValid <= 1'b0;
            pcF      <= pcTargetE;
            state    <= FETCH;
            reqQ     <= 1'b1;
          end else if (!stallD) begin
            bufValid <= 1'b0;
            state    <= FETCH;
            reqQ     <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          reqQ  <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg ifId (
    .clk      (clk),
    .rst      (rst),
    .stall    (stallD),
    .flush    (flushD),
    .inValid  (delivValid),
    .inInstr  (delivInstr),
    .inPc     (delivPc),
    .instrD   (instrD),
    .pcD      (pcD),
    .pcPlus4D (pcPlus4D),
    .validD   (validD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stall/flush/redirect/latency traffic, all compared against a queue-based
// reference model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallD = 1'b0;
  logic        flushD = 1'b0;
  logic        pcSrcE = 1'b0;
  logic [31:0] pcTargetE = '0;
  logic        imemAck = 1'b0;
  logic [31:0] imemRdata = '0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pcPlus4D;
  logic        validD;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .stallD    (stallD),
    .flushD    (flushD),
    .pcSrcE    (pcSrcE),
    .pcTargetE (pcTargetE),
    .imemReq   (imemReq),
    .imemAddr  (imemAddr),
    .imemAck   (imemAck),
    .imemRdata (imemRdata),
    .instrD    (instrD),
    .pcD       (pcD),
    .pcPlus4D  (pcPlus4D),
    .validD    (validD)
  );

  // Reference model: fetch pointer, pending redirect, skid queue, decode slot.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entryT;

  entryT       skidQ[$];
  bit          mStarted;
  bit          mDropping;
  logic [31:0] mPc;
  logic [31:0] mRedir;
  logic [31:0] eInstr, ePc, ePc4;
  bit          eValid;

  // Memory model state.
  bit          memBusy;
  int unsigned memWait;
  int unsigned latMin = 0;
  int unsigned latMax = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A3C_0F00;
  endfunction

  function automatic bit mReq();
    return mStarted && (skidQ.size() == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    assert (got === exp) else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string ph);
    check({ph, ".imemReq"}, {31'b0, imemReq}, {31'b0, mReq()});
    if (mReq()) check({ph, ".imemAddr"}, imemAddr, mPc);
    check({ph, ".instrD"}, instrD, eInstr);
    check({ph, ".validD"}, {31'b0, validD}, {31'b0, eValid});
    check({ph, ".pcD"}, pcD, ePc);
    check({ph, ".pcPlus4D"}, pcPlus4D, ePc4);
  endtask

  task automatic resetModel();
    skidQ.delete();
    mStarted  = 0;
    mDropping = 0;
    mPc       = RST_PC;
    mRedir    = '0;
    eInstr    = NOP;
    eValid    = 0;
    ePc       = '0;
    ePc4      = 32'd4;
    memBusy   = 0;
    memWait   = 0;
  endtask

  // Asynchronous reset mid-cycle; memory acks throughout reset and must be ignored.
  task automatic doReset();
    rst = 1'b1;
    #1;
    resetModel();
    checkAll("rstAsync");
    stallD = 0; flushD = 0; pcSrcE = 0;
    imemAck = 1'b1;
    imemRdata = 32'hBAD0_0BAD;
    repeat (2) @(posedge clk);
    #1;
    checkAll("rstHold");
    imemAck = 1'b0;
    rst = 1'b0;
  endtask

  // One clock: check outputs, drive inputs, advance the model, step past the edge.
  task automatic cycle(input bit s, input bit f, input bit p, input logic [31:0] t);
    bit    ack;
    bit    deliver;
    entryT dEnt;
    checkAll("cyc");
    stallD = s; flushD = f; pcSrcE = p; pcTargetE = t;
    ack = 0;
    if (mReq()) begin
      if (!memBusy) begin
        memBusy = 1;
        memWait = $urandom_range(latMax, latMin);
      end
      ack = (memWait == 0);
    end
    imemAck   = ack;
    imemRdata = ack ? memWord(mPc) : 32'hDEAD_BEEF;

    deliver = 0;
    dEnt = '{NOP, 32'h0};
    if (!mStarted) begin
      mStarted = 1;
    end else if (skidQ.size() != 0) begin
      if (p) begin
        skidQ.delete();
        mPc = t;
      end else if (!s) begin
        dEnt = skidQ.pop_front();
        deliver = 1;
      end
    end else if (mDropping) begin
      if (p) mRedir = t;
      if (ack) begin
        mPc = mRedir;
        mDropping = 0;
      end
    end else if (ack) begin
      if (p) mPc = t;
      else begin
        dEnt = '{imemRdata, mPc};
        mPc = mPc + 32'd4;
        if (s) skidQ.push_back(dEnt);
        else deliver = 1;
      end
    end else if (p) begin
      mRedir = t;
      mDropping = 1;
    end

    if (f) begin
      eInstr = NOP;
      eValid = 0;
    end else if (!s) begin
      if (deliver) begin
        eInstr = dEnt.instr;
        ePc    = dEnt.pc;
        ePc4   = dEnt.pc + 32'd4;
        eValid = 1;
      end else begin
        eInstr = NOP;
        eValid = 0;
      end
    end

    if (memBusy) begin
      if (ack) memBusy = 0;
      else memWait--;
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] tgt;
    bit s, f, p;

    // Reset and zero-wait streaming from RESET_PC.
    resetModel();
    @(posedge clk); #1;
    doReset();
    latMin = 0; latMax = 0;
    cycle(0, 0, 0, '0);
    check("stream.addr0", imemAddr, 32'h100);
    cycle(0, 0, 0, '0);
    check("stream.addr1", imemAddr, 32'h104);
    check("stream.instr0", instrD, memWord(32'h100));
    cycle(0, 0, 0, '0);
    check("stream.addr2", imemAddr, 32'h108);
    check("stream.valid", {31'b0, validD}, 32'd1);

    // Decode stall for three cycles while an ack returns.
    held = imemAddr;
    cycle(1, 0, 0, '0);
    check("stall.reqDrop", {31'b0, imemReq}, 32'd0);
    check("stall.dHeld", pcD, 32'h104);
    cycle(1, 0, 0, '0);
    cycle(1, 0, 0, '0);
    latMin = 3; latMax = 3;
    cycle(0, 0, 0, '0);
    check("stall.release", pcD, held);
    check("stall.nextAddr", imemAddr, held + 32'd4);

    // Redirect in the first wait cycle of a slow fetch.
    held = imemAddr;
    cycle(0, 0, 1, 32'h200);
    check("drop.addrHeld", imemAddr, held);
    cycle(0, 0, 0, '0);
    cycle(0, 0, 0, '0);
    latMin = 0; latMax = 0;
    cycle(0, 0, 0, '0);
    check("drop.target", imemAddr, 32'h200);
    check("drop.bubble", {31'b0, validD}, 32'd0);

    // Redirect coinciding with a zero-wait ack.
    cycle(0, 0, 1, 32'h300);
    check("redirAck.addr", imemAddr, 32'h300);
    check("redirAck.bubble", {31'b0, validD}, 32'd0);
    cycle(0, 0, 0, '0);

    // Fetch at the top of the address space wraps to zero.
    cycle(0, 0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0, '0);
    check("wrap.pcD", pcD, 32'hFFFF_FFFC);
    check("wrap.pcPlus4D", pcPlus4D, 32'h0);
    check("wrap.addr", imemAddr, 32'h0);

    // Flush alone inserts a bubble without disturbing the fetch stream.
    cycle(0, 1, 0, '0);
    check("flush.bubble", instrD, NOP);
    cycle(0, 0, 0, '0);

    // Reset while a request waits for its ack.
    latMin = 3; latMax = 3;
    cycle(0, 0, 0, '0);
    cycle(0, 0, 0, '0);
    doReset();
    latMin = 0; latMax = 0;
    cycle(0, 0, 0, '0);
    check("rstRestart.addr", imemAddr, RST_PC);
    cycle(0, 0, 0, '0);

    // Random traffic.
    latMin = 0; latMax = 3;
    for (int i = 0; i < 600; i++) begin
      s = ($urandom_range(3, 0) == 0);
      f = ($urandom_range(7, 0) == 0);
      p = ($urandom_range(7, 0) == 0);
      tgt = $urandom();
      tgt[1:0] = 2'b00;
      if ($urandom_range(7, 0) == 0) tgt = 32'hFFFF_FFFC;
      cycle(s, f, p, tgt);
    end
    cycle(0, 0, 0, '0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
